cassette_rec: RTL
=================

Name: cassette_rec

Overview:
- Record-side counterpart of the cassette player: decodes the FSK cassette-out signal from the SVI core into bytes and writes them sequentially into the tape image in SDRAM.
- Uses the same 21-bit byte-addressed SDRAM port and the same rising-edge available/ready handshake as the playback path.
- Captures CSAVE output into the image so the playback path can replay it. A 4-entry FIFO decouples bit decoding from SDRAM latency.

Parameters:
THRESH, 6711, half-period length in clk cycles separating short (2400 Hz) from long (1200 Hz); sized for a 21.477 MHz clk.
TIMEOUT, 20000, cycles with no din edge before the decoder abandons the current bit/byte.
MIN_PULSE, 1000, shortest accepted half-period; only used when CASREC_GLITCH_FILTER_EN is defined.
CNT_W, 16, width of the half-period counter; the counter saturates at all-ones.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
record  in  1  level; high means recording
rewind  in  1  rising edge sets sdram_addr to 0; honoured only while record is low
din  in  1  cassette-out bit from the core, asynchronous
sdram_addr  out  21  byte address of the next write
sdram_data  out  8  write data, equal to the FIFO head
sdram_wr  out  1  write request
sdram_available  in  1  rising edge means the port may be requested
sdram_ready  in  1  rising edge means the write is complete
status  out  3  {overflow, writer_busy, recording}

Behaviour:
- Clocking and reset: single clk domain; the reset is synchronous and active-high.
- Reset values: sdram_addr=0, sdram_wr=0, sdram_data=0, status=0, FIFO empty, all FSMs idle.
- Reset mid-transaction drops sdram_wr on the next edge; the in-flight byte is lost.
- din handling: passes through a 2-flop synchroniser. Each edge latches the counter value as the half-period, then clears the counter.
  - half < THRESH is classed as S; half >= THRESH is classed as L.
- Bit decoder runs only while record=1:
  - 2 consecutive L give bit 0; 4 consecutive S give bit 1.
  - An S/L mix before a bit completes discards the partial run. The new half-period starts the next run.
- Timeout: counter reaching TIMEOUT with no edge clears the bit decoder and sends the framer to HUNT; any partial byte is discarded.
- Framer FSM: HUNT -> DATA -> STOP -> HUNT.
  - HUNT: wait for bit 0 (start bit).
  - DATA: shift in 8 bits, LSB first.
  - STOP: first bit must be 1. If 1, push the byte (one cycle after that bit completes) and go to HUNT. If 0, discard the byte, treat that 0 as a new start bit, and go to DATA.
  - A second stop bit is absorbed by HUNT as idle 1.
- FIFO: 4 entries.
  - A push when full drops the byte and sets the sticky overflow flag. overflow clears on reset or an honoured rewind.
  - A push and pop in the same cycle are both allowed.
- Writer FSM: W_IDLE -> W_AVAIL -> W_READY -> W_IDLE.
  - W_IDLE: when the FIFO is non-empty, go to W_AVAIL.
  - W_AVAIL: on a rising edge of sdram_available (compared against the prior-cycle registered value), set sdram_wr=1 and go to W_READY.
  - W_READY: on a rising edge of sdram_ready, set sdram_wr=0, pop, set sdram_addr += 1 (wraps 0x1FFFFF -> 0), and go to W_IDLE.
  - sdram_data holds stable while sdram_wr=1.
- Record rising edge: decoder and framer restart in HUNT. sdram_addr is kept, so a new recording appends.
- Record falling edge: decoder stops and any partial byte is discarded. The writer drains the FIFO fully; recording=0 immediately.
- Rewind rising edge with record=0:
  - The FIFO is flushed.
  - If the writer is idle, sdram_addr=0 at once.
  - If the writer is mid-write, the transfer completes and then sdram_addr=0.
- Rewind with record=1 is ignored. Rewind and record rising on the same cycle: rewind is honoured first, then recording starts.
- status bits: writer_busy is 1 in W_AVAIL or W_READY; recording equals the registered record.

Optional Feature:
CASREC_GLITCH_FILTER_EN
- Defined: half-periods shorter than MIN_PULSE are ignored. The counter is not cleared and the edge produces no symbol.
- Undefined: every synchronised edge produces a symbol, and MIN_PULSE is unused.

Test Plan:
All scenarios use bench overrides THRESH=12, TIMEOUT=40, S=8 cycles, L=16 cycles.
1. Record=1; send idle 1s, then frame 0x55 (start 0, data, stop 1,1); pulse available then ready -> one write with sdram_data=0x55 at addr 0, then sdram_addr=1.
2. Frames 0xA3, 0x00, 0xFF back-to-back with a prompt responder -> writes at addr 0,1,2 in order, sdram_addr=3.
3. Hold sdram_available low; send 5 frames -> first 4 buffered, 5th dropped, status[2]=1; then release the handshake -> exactly 4 writes.
4. Send start + 4 data bits, then a 50-cycle silence, then frame 0x3C -> only 0x3C written.
5. Frame with stop bit 0 -> byte discarded, no write; the following frame 0x12 decodes correctly.
6. Reset asserted while sdram_wr=1 -> next cycle sdram_wr=0, sdram_addr=0, status=0. With record=0, rewind during W_READY -> write completes, then sdram_addr=0.

Source files
------------

// File: rtl/cassette_rec_if.sv
// rtl/cassette_rec_if.sv - SDRAM write port between the cassette recorder and the tape image memory
interface cassette_rec_if;
    logic [20:0] sdram_addr;
    logic [7:0]  sdram_data;
    logic        sdram_wr;
    logic        sdram_available;
    logic        sdram_ready;

    modport master (
        output sdram_addr, sdram_data, sdram_wr,
        input  sdram_available, sdram_ready
    );

    modport slave (
        input  sdram_addr, sdram_data, sdram_wr,
        output sdram_available, sdram_ready
    );
endinterface

// File: rtl/cassette_rec.sv
// rtl/cassette_rec.sv - FSK cassette-out decoder writing bytes into the SDRAM tape image
// Optional half-period glitch filter: CASREC_GLITCH_FILTER_EN
module cassette_rec #(
    parameter int THRESH    = 6711,
    parameter int TIMEOUT   = 20000,
    parameter int MIN_PULSE = 1000,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               record,
    input  logic               rewind,
    input  logic               din,
    output logic [2:0]         status,
    cassette_rec_if.master     bus
);
`ifdef CASREC_GLITCH_FILTER_EN
    localparam bit GLITCH_EN = 1'b1;
`else
    localparam bit GLITCH_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PULSE);

    typedef enum logic [1:0] {HUNT, DATA, STOP} frame_t;
    typedef enum logic [1:0] {W_IDLE, W_AVAIL, W_READY} wstate_t;

    logic             din_s1, din_s2, din_d;
    logic [CNT_W-1:0] cnt;
    logic             rec_q, rew_q, avail_q, ready_q;
    logic             run_long, bit_valid, bit_val;
    logic [2:0]       run_cnt;
    frame_t           fstate;
    logic [7:0]       shreg, push_data;
    logic [2:0]       bit_idx;
    logic             push;
    logic [7:0]       mem [4];
    logic [1:0]       wr_ptr, rd_ptr;
    logic [2:0]       count;
    wstate_t          wstate;
    logic             overflow, rew_pend, wr_r;
    logic [20:0]      addr_r;
    logic [7:0]       data_r;

    logic edge_raw, edge_ok, is_long, timeout, dec_run, rew_ok;
    logic avail_rise, ready_rise, pop, do_push;

    always_comb begin
        edge_raw   = din_s2 ^ din_d;
        // A filtered edge neither clears the counter nor produces a symbol.
        edge_ok    = edge_raw && (!GLITCH_EN || cnt >= MIN_C);
        is_long    = cnt >= THRESH_C;
        timeout    = !edge_ok && cnt == TIMEOUT_C;
        dec_run    = record && rec_q;
        rew_ok     = rewind && !rew_q && !rec_q;
        avail_rise = bus.sdram_available && !avail_q;
        ready_rise = bus.sdram_ready && !ready_q;
        pop        = wstate == W_READY && ready_rise && !rew_pend;
        do_push    = push && (count != 3'd4 || pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            din_s1 <= 1'b0; din_s2 <= 1'b0; din_d <= 1'b0;
            cnt <= '0;
            rec_q <= 1'b0; rew_q <= 1'b0; avail_q <= 1'b0; ready_q <= 1'b0;
        end else begin
            din_s1  <= din;
            din_s2  <= din_s1;
            din_d   <= din_s2;
            rec_q   <= record;
            rew_q   <= rewind;
            avail_q <= bus.sdram_available;
            ready_q <= bus.sdram_ready;
            if (edge_ok)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end

    // Symbol run decoder: 2 long halves -> 0, 4 short halves -> 1.
    always_ff @(posedge clk) begin
        if (reset || !dec_run || timeout) begin
            run_cnt <= '0; run_long <= 1'b0; bit_valid <= 1'b0; bit_val <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            if (edge_ok) begin
                if (run_cnt != 3'd0 && run_long != is_long) begin
                    run_cnt  <= 3'd1;
                    run_long <= is_long;
                end else if (is_long && run_cnt == 3'd1) begin
                    bit_valid <= 1'b1; bit_val <= 1'b0; run_cnt <= '0;
                end else if (!is_long && run_cnt == 3'd3) begin
                    bit_valid <= 1'b1; bit_val <= 1'b1; run_cnt <= '0;
                end else begin
                    run_cnt  <= run_cnt + 3'd1;
                    run_long <= is_long;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !dec_run || timeout) begin
            fstate <= HUNT; bit_idx <= '0; push <= 1'b0;
            if (reset) begin
                shreg <= '0; push_data <= '0;
            end
        end else begin
            push <= 1'b0;
            if (bit_valid) begin
                unique case (fstate)
                    HUNT: if (!bit_val) begin
                        fstate  <= DATA;
                        bit_idx <= '0;
                    end
                    DATA: begin
                        shreg   <= {bit_val, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) fstate <= STOP;
                    end
                    default: begin
                        // A 0 stop bit doubles as the start bit of the next frame.
                        if (bit_val) begin
                            push      <= 1'b1;
                            push_data <= shreg;
                            fstate    <= HUNT;
                        end else begin
                            fstate  <= DATA;
                            bit_idx <= '0;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rew_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0; rd_ptr <= '0; count <= '0; overflow <= 1'b0;
            wstate <= W_IDLE; wr_r <= 1'b0; addr_r <= '0; data_r <= '0; rew_pend <= 1'b0;
        end else begin
            if (rew_ok) begin
                wr_ptr <= '0; rd_ptr <= '0; count <= '0; overflow <= 1'b0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 2'd1;
                if (push && !do_push) overflow <= 1'b1;
                if (pop) rd_ptr <= rd_ptr + 2'd1;
                unique case ({do_push, pop})
                    2'b10:   count <= count + 3'd1;
                    2'b01:   count <= count - 3'd1;
                    default: ;
                endcase
            end
            if (wstate != W_READY && count != 3'd0) data_r <= mem[rd_ptr];
            unique case (wstate)
                W_IDLE: begin
                    if (rew_ok) addr_r <= '0;
                    else if (count != 3'd0) wstate <= W_AVAIL;
                end
                W_AVAIL: begin
                    if (rew_ok) begin
                        addr_r <= '0;
                        wstate <= W_IDLE;
                    end else if (avail_rise) begin
                        wr_r   <= 1'b1;
                        wstate <= W_READY;
                    end
                end
                default: begin
                    if (rew_ok) rew_pend <= 1'b1;
                    if (ready_rise) begin
                        wr_r     <= 1'b0;
                        addr_r   <= (rew_pend || rew_ok) ? 21'd0 : addr_r + 21'd1;
                        rew_pend <= 1'b0;
                        wstate   <= W_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.sdram_addr = addr_r;
    assign bus.sdram_data = data_r;
    assign bus.sdram_wr   = wr_r;
    assign status         = {overflow, wstate != W_IDLE, rec_q};
endmodule
